// File: rtl/mealy2_pkg.sv
// ----------------------------------------------------------------------------
// mealy2_pkg
// Shared definitions for the Mealy "four or more consecutive ones" detector.
//   ST_W      : width of the state vector {y1,y2}
//   estado_t  : 2-bit state type
//   ST_S0..3  : number of consecutive valid ones seen, saturating at three
// ----------------------------------------------------------------------------
package mealy2_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_S0 = 2'b00,  // no one yet
        ST_S1 = 2'b01,  // one consecutive one
        ST_S2 = 2'b10,  // two consecutive ones
        ST_S3 = 2'b11   // three or more consecutive ones
    } estado_t;

endpackage

// File: rtl/logica_comb_de_estado.sv
// ----------------------------------------------------------------------------
// logica_comb_de_estado
// Pure next-state function of the sequence detector.
//   i_w          : serial input bit
//   i_w_valid    : i_w is only considered when this is 1
//   i_y1, i_y2   : current state {MSB, LSB}
//   o_estado_sig : next state {y1,y2}
// An invalid cycle holds the state; a valid zero returns to S0; a valid one
// advances and saturates in S3 so that detection is overlapping.
// ----------------------------------------------------------------------------
module logica_comb_de_estado
    import mealy2_pkg::*;
(
    input  logic    i_w,
    input  logic    i_w_valid,
    input  logic    i_y1,
    input  logic    i_y2,
    output estado_t o_estado_sig
);

    estado_t w_estado;

    assign w_estado = estado_t'({i_y1, i_y2});

    always_comb begin
        o_estado_sig = w_estado;
        if (i_w_valid) begin
            if (!i_w) begin
                o_estado_sig = ST_S0;
            end else begin
                case (w_estado)
                    ST_S0:   o_estado_sig = ST_S1;
                    ST_S1:   o_estado_sig = ST_S2;
                    default: o_estado_sig = ST_S3;
                endcase
            end
        end
    end

endmodule

// File: rtl/registro_de_estado_mealy.sv
// ----------------------------------------------------------------------------
// registro_de_estado_mealy
// State register and next-state stage of the Mealy detector. Feeds the output
// stage, which computes z = w & y1 & y2.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; highest priority
//   w          : serial input bit
//   w_valid    : w is sampled only when 1
//   cnt_clr    : synchronous clear of det_count (wins over a detection)
//   y1, y2     : registered state {MSB, LSB}
//   w_out      : w & w_valid, drives the output stage's w
//   det_z      : w_out & y1 & y2, local copy of the downstream z
//   det_count  : saturating count of detections (CNT_W bits)
// Build option: MEALY2_DET_COUNT_EN compiles in the detection counter.
// Without it det_count is tied to 0 and cnt_clr is ignored.
// ----------------------------------------------------------------------------
module registro_de_estado_mealy
    import mealy2_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             w_valid,
    input  logic             cnt_clr,
    output logic             y1,
    output logic             y2,
    output logic             w_out,
    output logic             det_z,
    output logic [CNT_W-1:0] det_count
);

    estado_t r_estado;
    estado_t w_estado_sig;

    logica_comb_de_estado u_logica_comb_de_estado (
        .i_w          (w),
        .i_w_valid    (w_valid),
        .i_y1         (r_estado[1]),
        .i_y2         (r_estado[0]),
        .o_estado_sig (w_estado_sig)
    );

    always_ff @(posedge clk) begin
        if (reset) r_estado <= ST_S0;
        else       r_estado <= w_estado_sig;
    end

    assign y1 = r_estado[1];
    assign y2 = r_estado[0];

    // Gating w with w_valid keeps the downstream z low on invalid cycles.
    assign w_out = w & w_valid;
    assign det_z = w_out & y1 & y2;

`ifdef MEALY2_DET_COUNT_EN
    logic [CNT_W-1:0] r_det_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_det_count <= '0;
        else if (cnt_clr)
            r_det_count <= '0;
        else if (det_z && (r_det_count != {CNT_W{1'b1}}))
            r_det_count <= r_det_count + CNT_W'(1);
    end

    assign det_count = r_det_count;
`else
    // Counter compiled out; cnt_clr is intentionally left without effect.
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign det_count        = '0;
`endif

endmodule

// File: tb/tb_registro_de_estado_mealy.sv
// ----------------------------------------------------------------------------
// tb_registro_de_estado_mealy
// Directed-vector bench for registro_de_estado_mealy with CNT_W = 2.
// Expected counts depend on whether MEALY2_DET_COUNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_registro_de_estado_mealy;

    localparam int CNT_W = 2;
`ifdef MEALY2_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             w;
    logic             w_valid;
    logic             cnt_clr;
    logic             y1;
    logic             y2;
    logic             w_out;
    logic             det_z;
    logic [CNT_W-1:0] det_count;

    int checks   = 0;
    int failures = 0;

    registro_de_estado_mealy #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .w         (w),
        .w_valid   (w_valid),
        .cnt_clr   (cnt_clr),
        .y1        (y1),
        .y2        (y2),
        .w_out     (w_out),
        .det_z     (det_z),
        .det_count (det_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected count when the counter is built in, 0 otherwise.
    function automatic logic [31:0] ecnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    // Drive one cycle: check combinational outputs before the edge and the
    // registered state after it. Inputs change 1 time unit after posedge.
    task automatic samp(input string tag, input logic iw, input logic iv,
                        input logic ic, input logic exp_dz, input logic [1:0] exp_st);
        w = iw; w_valid = iv; cnt_clr = ic;
        #1;
        chk({tag, ".w_out"}, 32'(w_out), 32'(iw & iv));
        chk({tag, ".det_z"}, 32'(det_z), 32'(exp_dz));
        @(posedge clk); #1;
        chk({tag, ".st"}, 32'({y1, y2}), 32'(exp_st));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; w = 1'b1; w_valid = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".rst_st"}, 32'({y1, y2}), 32'd0);
        chk({tag, ".rst_cnt"}, 32'(det_count), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; w = 1'b0; w_valid = 1'b0; cnt_clr = 1'b0;
        @(posedge clk); #1;

        // Reset with w=1, w_valid=1 held; no detection right after release.
        do_reset("reset");
        samp("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

        // Sequence 1,1,1,1,1,0,1
        samp("seq0", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        samp("seq1", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        samp("seq2", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        samp("seq3", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        samp("seq4", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        samp("seq5", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        samp("seq6", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        chk("seq.cnt", 32'(det_count), ecnt(2));

        // Gaps: w held at 1 with w_valid low between valid samples.
        do_reset("gap");
        samp("gap.v0", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) samp("gap.g0", 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        samp("gap.v1", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++) samp("gap.g1", 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        samp("gap.v2", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        for (int i = 0; i < 3; i++) samp("gap.g2", 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        samp("gap.v3", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("gap.cnt", 32'(det_count), ecnt(1));

        // Saturation at 2^CNT_W-1 = 3 after six detections.
        do_reset("sat");
        samp("sat.a", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        samp("sat.b", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        samp("sat.c", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        samp("sat.d1", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("sat.cnt1", 32'(det_count), ecnt(1));
        for (int i = 0; i < 5; i++) samp("sat.dn", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("sat.cnt6", 32'(det_count), ecnt(3));
        samp("sat.d7", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("sat.cnt7", 32'(det_count), ecnt(3));

        // Clear collides with a detection: clear wins, state stays S3.
        samp("clr.hit", 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        chk("clr.cnt", 32'(det_count), ecnt(0));
        samp("clr.next", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("clr.cnt_inc", 32'(det_count), ecnt(1));

        // Reset while in S3 with a detection pending on the inputs.
        reset = 1'b1; w = 1'b1; w_valid = 1'b1; cnt_clr = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst.st", 32'({y1, y2}), 32'd0);
        chk("mid_rst.cnt", 32'(det_count), 32'd0);
        reset = 1'b0;
        samp("mid_rst.after", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/registro_de_estado_mealy.md
# registro_de_estado_mealy

State-register and next-state stage of the Mealy sequence detector, feeding `logica_comb_de_salida` directly upstream. It counts consecutive valid `1` samples on `w`, saturating at three, and presents the 2-bit state as `y1`/`y2`. The output stage then asserts `z = w & y1 & y2`, which detects the fourth and every later consecutive `1`. It also provides a qualified input copy to the output stage and, optionally, a detection counter.

## Interface
- `CNT_W`, default 8: width of the detection counter `det_count`.
- `clk`  in  1  single system clock; rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `w`  in  1  serial input bit.
- `w_valid`  in  1  `w` is sampled only on cycles where this is 1.
- `cnt_clr`  in  1  synchronous clear of `det_count`.
- `y1`  out  1  state MSB, registered.
- `y2`  out  1  state LSB, registered.
- `w_out`  out  1  `w & w_valid`, combinational; drives the output stage's `w`.
- `det_z`  out  1  `w_out & y1 & y2`, combinational; mirrors the downstream `z` for local use.
- `det_count`  out  `CNT_W`  number of detections, registered.

## Operation
- State encoding `{y1,y2}`:
  - `S0 = 00`: no `1` yet.
  - `S1 = 01`: one consecutive `1`.
  - `S2 = 10`: two consecutive `1`s.
  - `S3 = 11`: three or more consecutive `1`s.
- Transitions, applied only when `w_valid = 1`:
  - `w = 1`: S0→S1, S1→S2, S2→S3, S3→S3 (saturates; detection is overlapping).
  - `w = 0`: any state → S0.
- `w_valid = 0`: the state holds. It is neither reset nor advanced.
- `w_out` is forced to 0 when `w_valid = 0`, so the downstream `z` cannot assert on an invalid cycle.
- Detection event: `det_z = 1`, i.e. a valid `w = 1` while in S3.
- `det_count`:
  - Increments by 1 on each edge where `det_z = 1`.
  - Saturates at `2^CNT_W − 1` and does not wrap.
- `cnt_clr = 1` zeroes `det_count` at the next edge. If a detection occurs on the same cycle, the clear wins and the result is 0.
- `reset` has priority over everything: state becomes S0 and `det_count` becomes 0. The same applies when reset is asserted mid-sequence.

## Timing
- Reset values: `y1 = 0`, `y2 = 0`, `det_count = 0`. `w_out` and `det_z` are combinational; they follow the inputs and equal 0 when `w_valid = 0`.
- A valid sample on cycle n is reflected in `y1`/`y2` after edge n, so it is visible on cycle n+1.
- `det_z`/`z` are valid in the same cycle as the sampled `w` (Mealy behaviour, zero latency). `det_count` reflects the detection one cycle later.
- Reset asserted on cycle n: on cycle n+1 all registers hold their reset values, regardless of `w_valid`, `w` or `cnt_clr`.
- No handshake back-pressure. The block accepts one sample per valid cycle, and `w_valid` may toggle every cycle.

## Configuration
- Macro `MEALY2_DET_COUNT_EN`.
- Defined: the detection counter, its saturation logic and `cnt_clr` handling are compiled in, as described above.
- Undefined: the counter logic is removed, `det_count` is tied to 0 and `cnt_clr` is ignored. The port list is unchanged. State, `w_out` and `det_z` behaviour is identical in both builds.

## Structure
- Shared package `mealy2_pkg`:
  - State width constant `ST_W = 2`.
  - State constants `ST_S0..ST_S3` with the encoding above.
  - `typedef` `estado_t` for the 2-bit state.
- One sub-module, `logica_comb_de_estado`: pure next-state function of (`w`, `w_valid`, `y1`, `y2`) giving the next `{y1,y2}`.
- The top holds the state flip-flops, the `w_out`/`det_z` gating and the conditional counter.

## Test plan
- Reset: hold `reset = 1` for 2 cycles with `w = 1`, `w_valid = 1` → `{y1,y2} = 00`, `det_count = 0`, and `det_z` is not asserted on the cycle after reset is released.
- Sequence: valid `w = 1,1,1,1,1,0,1` → state 01,10,11,11,11,00,01; `det_z = 1` only on the 4th and 5th samples; `det_count = 2`.
- Gaps: `w = 1,1,1` with `w_valid` low for 3 cycles between samples, then valid `w = 1` → state holds at 11 during the gaps, `w_out = 0` during the gaps, one detection occurs, `det_count = 1`.
- Saturation: with `CNT_W = 2`, feed 6 detections → `det_count = 3` and stays at 3.
- Clear collision: `cnt_clr = 1` on the same cycle as a detection → `det_count = 0` on the next cycle; state remains 11.
- Mid-sequence reset and build check: assert `reset` while in S3 → next cycle state 00 and count 0. With the macro undefined, repeat the sequence test → `det_count` stays 0 and `det_z` is unchanged.
